// File: rtl/serial_word_loader_pkg.sv
// Shared constants and sizing helpers for the serial word loader.
// SERIAL_WORD_LOADER_PARITY_EN adds a trailing odd-parity bit per frame.
package serial_word_loader_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int frame_len(input int w);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/slw_fifo.sv
// DEPTH x WIDTH register FIFO with wrap-bit pointers.
// Push while full is only legal together with a pop.
module slw_fifo
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = ptr_w(DEPTH),
  localparam int AW = PW - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr;
  logic [PW-1:0]    rd;

  assign empty = (wr == rd);
  assign full  = (wr[PW-1] != rd[PW-1]) &&
                 (wr[AW-1:0] == rd[AW-1:0]);
  assign level = wr - rd;
  assign head  = empty ? '0 : mem[rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// LSB-first serial deserialiser feeding a small word FIFO.
// Parity checking is enabled by SERIAL_WORD_LOADER_PARITY_EN.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [PW-1:0]    fill_level,
  output logic             overflow,
  output logic             parity_err
);

  localparam int FL = frame_len(WIDTH);
  localparam int CW = $clog2(FL);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  logic [CW-1:0] bit_cnt;
  logic [FL-1:0] sr;
  logic [FL-1:0] sr_next;
  logic          done;
  logic          par_ok;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  always_comb begin
    sr_next = sr;
    sr_next[bit_cnt] = ser_in;
  end

  assign done = ser_valid && (bit_cnt == LAST);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  assign par_ok = ^sr_next;
`else
  assign par_ok = 1'b1;
`endif

  assign pop        = word_valid && word_ready;
  assign push_req   = done && !clr && par_ok;
  assign push       = push_req && (!full || pop);
  assign word_valid = !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      sr       <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      bit_cnt  <= '0;
      sr       <= '0;
      overflow <= 1'b0;
    end else begin
      if (ser_valid) begin
        sr      <= sr_next;
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
      end
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else if (clr) parity_err <= 1'b0;
    else if (done && !par_ok) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

  slw_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (sr_next[WIDTH-1:0]),
    .head (word_out),
    .full (full),
    .empty(empty),
    .level(fill_level)
  );

endmodule
